// File: rtl/l2_arb_pkg.sv
// Shared types and helpers for the L2 TCDM round-robin arbiter.
//   tcdm_req_t : slave-side request payload (add, wen, wdata, be)
//   tcdm_rsp_t : slave-side response payload (rdata)
//   idx_w      : index width for N items (at least 1 bit)
//   rr_pick    : first set bit of req_vec at or after ptr, wrapping at n
package l2_arb_pkg;

  localparam int unsigned L2_ADDR_W   = 32;
  localparam int unsigned L2_DATA_W   = 32;
  localparam int unsigned L2_BE_W     = L2_DATA_W / 8;
  localparam int unsigned MAX_MASTERS = 32;
  localparam int unsigned MAX_IDX_W   = 5;

  typedef struct packed {
    logic [L2_ADDR_W-1:0] add;
    logic                 wen;
    logic [L2_DATA_W-1:0] wdata;
    logic [L2_BE_W-1:0]   be;
  } tcdm_req_t;

  typedef struct packed {
    logic [L2_DATA_W-1:0] rdata;
  } tcdm_rsp_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Scan n positions starting at ptr; constant trip count keeps it synthesizable.
  function automatic int unsigned rr_pick(input logic [MAX_MASTERS-1:0] req_vec,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && req_vec[idx[MAX_IDX_W-1:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/l2_arb_id_fifo.sv
// In-order ID FIFO: remembers which master owns each outstanding transaction.
// Ports:
//   i_clk, i_clr (sync active-high clear)
//   i_push/i_push_data : enqueue a master index (ignored when full)
//   i_pop              : dequeue the head (ignored when empty)
//   o_pop_data         : current head index
//   o_full/o_empty     : occupancy flags
module l2_arb_id_fifo
  import l2_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  // Full blocks a push even when a pop happens in the same cycle.
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_full     = (r_cnt == CNT_W'(DEPTH));
  assign o_empty    = (r_cnt == '0);
  assign o_pop_data = r_mem[r_rd_ptr];

  // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/l2_tcdm_rr_arbiter.sv
// Shares one L2 TCDM slave port among NB_MASTERS masters.
// Round-robin arbitration with a high-priority class (HI_PRIO_MASK), a winner
// lock while the slave stalls, and an in-order ID FIFO that routes responses.
// Ports:
//   clk_i, rst_i (sync active-high)
//   m_req_i/m_add_i/m_wen_i/m_wdata_i/m_be_i : flattened per-master requests
//   m_gnt_o, m_r_valid_o, m_r_rdata_o        : per-master grant / response
//   s_req_o/s_add_o/s_wen_o/s_wdata_o/s_be_o : muxed request to L2
//   s_gnt_i, s_r_valid_i, s_r_rdata_i        : L2 grant / in-order response
//   err_o                                    : sticky, response with no owner
module l2_tcdm_rr_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned            NB_MASTERS   = 4,
  parameter int unsigned            ADDR_W       = L2_ADDR_W,
  parameter int unsigned            DATA_W       = L2_DATA_W,
  parameter int unsigned            MAX_OUTST    = 4,
  parameter logic [NB_MASTERS-1:0]  HI_PRIO_MASK = NB_MASTERS'(1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_MASTERS-1:0]          m_req_i,
  input  logic [NB_MASTERS*ADDR_W-1:0]   m_add_i,
  input  logic [NB_MASTERS-1:0]          m_wen_i,
  input  logic [NB_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [NB_MASTERS*DATA_W/8-1:0] m_be_i,
  output logic [NB_MASTERS-1:0]          m_gnt_o,
  output logic [NB_MASTERS-1:0]          m_r_valid_o,
  output logic [DATA_W-1:0]              m_r_rdata_o,
  output logic                           s_req_o,
  output logic [ADDR_W-1:0]              s_add_o,
  output logic                           s_wen_o,
  output logic [DATA_W-1:0]              s_wdata_o,
  output logic [DATA_W/8-1:0]            s_be_o,
  input  logic                           s_gnt_i,
  input  logic                           s_r_valid_i,
  input  logic [DATA_W-1:0]              s_r_rdata_i,
  output logic                           err_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = idx_w(NB_MASTERS);

  logic [NB_MASTERS-1:0] w_hi_req;
  logic [NB_MASTERS-1:0] w_elig;
  logic [IDX_W-1:0]      w_pick;
  logic [IDX_W-1:0]      w_winner;
  logic [IDX_W-1:0]      w_head;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W-1:0]      r_lock_idx;
  logic                  r_lock_vld;
  logic                  r_err;
  logic                  w_lock_hold;
  logic                  w_lock_drop;
  logic                  w_req;
  logic                  w_hs;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  tcdm_req_t             w_sel;
  tcdm_rsp_t             w_rsp;

  // Arbitration: high-priority filter, round-robin pick, then the stall lock.
  always_comb begin
    w_hi_req    = m_req_i & HI_PRIO_MASK;
    w_elig      = (|w_hi_req) ? w_hi_req : m_req_i;
    w_pick      = IDX_W'(rr_pick(MAX_MASTERS'(w_elig), 32'(r_rr_ptr), NB_MASTERS));
    w_lock_hold = r_lock_vld && m_req_i[r_lock_idx];
    // A locked master that withdraws costs one idle cycle before re-arbitration.
    w_lock_drop = r_lock_vld && !m_req_i[r_lock_idx];
    w_winner    = w_lock_hold ? r_lock_idx : w_pick;
    w_req       = !rst_i && !w_lock_drop && (|w_elig) && !w_full;
    w_hs        = w_req && s_gnt_i;
  end

  // Slave-side payload mux; idle bus reads as a zeroed read.
  always_comb begin
    w_sel     = '0;
    w_sel.wen = 1'b1;
    if (w_req) begin
      w_sel.add   = L2_ADDR_W'(m_add_i[w_winner*ADDR_W +: ADDR_W]);
      w_sel.wen   = m_wen_i[w_winner];
      w_sel.wdata = L2_DATA_W'(m_wdata_i[w_winner*DATA_W +: DATA_W]);
      w_sel.be    = L2_BE_W'(m_be_i[w_winner*BE_W +: BE_W]);
    end
  end

  assign s_req_o   = w_req;
  assign s_add_o   = ADDR_W'(w_sel.add);
  assign s_wen_o   = w_sel.wen;
  assign s_wdata_o = DATA_W'(w_sel.wdata);
  assign s_be_o    = BE_W'(w_sel.be);
  assign m_gnt_o   = w_hs ? (NB_MASTERS'(1) << w_winner) : '0;

  // Response demux: the FIFO head names the owner of the returning beat.
  assign w_pop       = s_r_valid_i && !w_empty && !rst_i;
  assign w_rsp.rdata = L2_DATA_W'(s_r_rdata_i);
  assign m_r_valid_o = w_pop ? (NB_MASTERS'(1) << w_head) : '0;
  assign m_r_rdata_o = DATA_W'(w_rsp.rdata);
  assign err_o       = r_err;

  l2_arb_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .i_clk       (clk_i),
    .i_clr       (rst_i),
    .i_push      (w_hs),
    .i_push_data (w_winner),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Round-robin pointer, stall lock and sticky orphan-response flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_lock_vld <= 1'b0;
      r_lock_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      // High-priority grants leave the fairness order of the others untouched.
      if (w_hs && !HI_PRIO_MASK[w_winner]) begin
        r_rr_ptr <= (w_winner == IDX_W'(NB_MASTERS - 1)) ? '0 : w_winner + IDX_W'(1);
      end
      if (w_hs) begin
        r_lock_vld <= 1'b0;
      end else if (w_req) begin
        r_lock_vld <= 1'b1;
        r_lock_idx <= w_winner;
      end else if (w_lock_drop) begin
        r_lock_vld <= 1'b0;
      end
      if (s_r_valid_i && w_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_tcdm_rr_arbiter.sv
module tb_l2_tcdm_rr_arbiter;

  localparam int NB = 4;
  localparam int MO = 4;
  localparam logic [NB-1:0] HI = 4'b0001;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    m_req, m_wen;
  logic [127:0]  m_add, m_wdata;
  logic [15:0]   m_be;
  logic          s_gnt, s_r_valid;
  logic [31:0]   s_r_rdata;
  logic [3:0]    m_gnt_o, m_r_valid_o;
  logic [31:0]   m_r_rdata_o, s_add_o, s_wdata_o;
  logic          s_req_o, s_wen_o, err_o;
  logic [3:0]    s_be_o;

  int checks = 0;
  int errors = 0;

  // Reference model: pointer, locked master (-1 none), owner queue, error flag.
  int mdl_ptr, mdl_lock, cyc = 0;
  int mdl_q[$];
  bit mdl_err;

  // L2 model: pending responses with due cycle, plus a sparse memory.
  typedef struct { int due; logic [31:0] data; } pend_t;
  pend_t pend[$];
  logic [31:0] mem [logic [31:0]];
  int l2_lat = 1;
  bit l2_en = 1'b0;
  int last_due = 0;

  always #5 clk = ~clk;

  l2_tcdm_rr_arbiter #(
    .NB_MASTERS(NB), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(MO), .HI_PRIO_MASK(HI)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_add_i(m_add), .m_wen_i(m_wen), .m_wdata_i(m_wdata), .m_be_i(m_be),
    .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o), .m_r_rdata_o(m_r_rdata_o),
    .s_req_o(s_req_o), .s_add_o(s_add_o), .s_wen_o(s_wen_o), .s_wdata_o(s_wdata_o),
    .s_be_o(s_be_o), .s_gnt_i(s_gnt), .s_r_valid_i(s_r_valid), .s_r_rdata_i(s_r_rdata),
    .err_o(err_o)
  );

  // Who would the rules pick right now (-1: nobody)?
  function automatic int mdl_winner();
    bit anyhi = 1'b0;
    int w;
    for (int i = 0; i < NB; i++) if (m_req[i] && HI[i]) anyhi = 1'b1;
    if (mdl_lock >= 0) return m_req[mdl_lock] ? mdl_lock : -1;
    for (int k = 0; k < NB; k++) begin
      w = (mdl_ptr + k) % NB;
      if (m_req[w] && (!anyhi || HI[w])) return w;
    end
    return -1;
  endfunction

  function automatic bit mdl_sreq();
    return !rst && (mdl_winner() >= 0) && (mdl_q.size() < MO);
  endfunction

  always @(posedge clk) begin : mdl_upd
    int w, due, a;
    bit sr;
    logic [31:0] d;
    w  = mdl_winner();
    sr = mdl_sreq();
    if (rst) begin
      mdl_ptr = 0; mdl_lock = -1; mdl_q.delete(); mdl_err = 1'b0;
      pend.delete(); last_due = 0;
    end else begin
      if (s_r_valid) begin
        if (mdl_q.size() > 0) void'(mdl_q.pop_front());
        else mdl_err = 1'b1;
      end
      if (sr && s_gnt) begin
        mdl_q.push_back(w);
        if (!HI[w]) mdl_ptr = (w + 1) % NB;
        mdl_lock = -1;
        a = m_add[w*32 +: 32];
        d = mem.exists(a) ? mem[a] : 32'h0;
        if (!m_wen[w]) begin
          for (int b = 0; b < 4; b++) if (m_be[w*4+b]) d[b*8 +: 8] = m_wdata[w*32 + b*8 +: 8];
          mem[a] = d;
          d = 32'h0;
        end
        due = cyc + l2_lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{due: due, data: d});
      end else if (sr) begin
        mdl_lock = w;
      end else if (mdl_lock >= 0 && !m_req[mdl_lock]) begin
        mdl_lock = -1;
      end
    end
    cyc++;
  end

  task automatic l2_drive();
    s_r_valid = 1'b0;
    s_r_rdata = $urandom;
    if (l2_en && pend.size() > 0 && pend[0].due <= cyc) begin
      s_r_valid = 1'b1;
      s_r_rdata = pend[0].data;
      void'(pend.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    l2_drive();
  endtask

  task automatic idle_inputs();
    m_req = '0; m_wen = 4'hF; m_add = '0; m_wdata = '0; m_be = '0; s_gnt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; l2_en = 1'b0; idle_inputs();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); s_r_valid = 1'b0; s_r_rdata = '0;
    tick();
    m_req = 4'hF; m_add = {4{32'h1234_5678}}; m_be = 16'hFFFF; m_wen = 4'h0;
    s_gnt = 1'b1; s_r_valid = 1'b1;
    @(negedge clk);
    if (s_req_o !== 1'b0) begin errors++; $display("FAIL rst_sreq got %b exp 0", s_req_o); end
    checks++;
    if (m_gnt_o !== 4'h0) begin errors++; $display("FAIL rst_gnt got %b exp 0000", m_gnt_o); end
    checks++;
    if (m_r_valid_o !== 4'h0) begin errors++; $display("FAIL rst_rvalid got %b exp 0000", m_r_valid_o); end
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_o); end
    checks++;
    if (s_wen_o !== 1'b1 || s_add_o !== 32'h0 || s_be_o !== 4'h0 || s_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_bus got wen=%b add=%h be=%h wd=%h exp 1/0/0/0", s_wen_o, s_add_o, s_be_o, s_wdata_o);
    end
    checks++;
    do_reset();
  endtask

  task automatic test_single();
    do_reset(); l2_en = 1'b1; l2_lat = 1;
    m_req = 4'b0010; m_wen[1] = 1'b0; m_add[63:32] = 32'h100; m_wdata[63:32] = 32'hDEADBEEF;
    m_be[7:4] = 4'hF; s_gnt = 1'b1;
    @(negedge clk);
    if (m_gnt_o !== 4'b0010) begin errors++; $display("FAIL single_wr_gnt got %b exp 0010", m_gnt_o); end
    checks++;
    if (s_add_o !== 32'h100 || s_wen_o !== 1'b0 || s_wdata_o !== 32'hDEADBEEF || s_be_o !== 4'hF) begin
      errors++;
      $display("FAIL single_wr_bus got add=%h wen=%b wd=%h be=%h", s_add_o, s_wen_o, s_wdata_o, s_be_o);
    end
    checks++;
    tick(); m_req = 4'b0000;
    @(negedge clk);
    if (m_r_valid_o !== 4'b0010) begin errors++; $display("FAIL single_wr_rsp got %b exp 0010", m_r_valid_o); end
    checks++;
    tick(); m_req = 4'b0010; m_wen[1] = 1'b1;
    @(negedge clk);
    if (m_gnt_o !== 4'b0010 || s_wen_o !== 1'b1) begin
      errors++; $display("FAIL single_rd_gnt got %b wen=%b exp 0010 wen=1", m_gnt_o, s_wen_o);
    end
    checks++;
    tick(); m_req = 4'b0000;
    @(negedge clk);
    if (m_r_valid_o !== 4'b0010 || m_r_rdata_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_rd_rsp got %b %h exp 0010 deadbeef", m_r_valid_o, m_r_rdata_o);
    end
    checks++;
    tick();
  endtask

  task automatic test_round_robin();
    int order[3] = '{1, 2, 3};
    int cnt[4] = '{0, 0, 0, 0};
    do_reset(); l2_en = 1'b1; l2_lat = 1;
    m_req = 4'b1110; s_gnt = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m_gnt_o !== 4'(1 << order[c % 3])) begin
        errors++; $display("FAIL rr_gnt c=%0d got %b exp m%0d", c, m_gnt_o, order[c % 3]);
      end
      checks++;
      if (c > 0) begin
        if (m_r_valid_o !== 4'(1 << order[(c - 1) % 3])) begin
          errors++; $display("FAIL rr_rsp c=%0d got %b exp m%0d", c, m_r_valid_o, order[(c - 1) % 3]);
        end
        checks++;
      end
      for (int i = 0; i < NB; i++) if (m_gnt_o[i] === 1'b1) cnt[i]++;
      tick();
    end
    for (int i = 0; i < NB; i++) begin
      if (cnt[i] != ((i == 0) ? 0 : 10)) begin
        errors++; $display("FAIL rr_share m%0d got %0d exp %0d", i, cnt[i], (i == 0) ? 0 : 10);
      end
      checks++;
    end
    idle_inputs(); tick();
  endtask

  task automatic test_hi_prio();
    do_reset(); l2_en = 1'b1; l2_lat = 1; s_gnt = 1'b1;
    m_req = 4'b0100;
    @(negedge clk);
    if (m_gnt_o !== 4'b0100) begin errors++; $display("FAIL hi_pre got %b exp 0100", m_gnt_o); end
    checks++;
    tick(); m_req = 4'b1011;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (m_gnt_o !== 4'b0001) begin errors++; $display("FAIL hi_only c=%0d got %b exp 0001", c, m_gnt_o); end
      checks++;
      tick();
    end
    m_req = 4'b1010;
    @(negedge clk);
    if (m_gnt_o !== 4'b1000) begin errors++; $display("FAIL hi_ptr_kept got %b exp 1000", m_gnt_o); end
    checks++;
    tick();
    @(negedge clk);
    if (m_gnt_o !== 4'b0010) begin errors++; $display("FAIL hi_rr_next got %b exp 0010", m_gnt_o); end
    checks++;
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_lock();
    do_reset(); l2_en = 1'b1; l2_lat = 1; s_gnt = 1'b0;
    m_add[63:32] = 32'h200; m_add[31:0] = 32'h300; m_req = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) m_req = 4'b0011;
      @(negedge clk);
      if (s_req_o !== 1'b1 || m_gnt_o !== 4'b0000 || s_add_o !== 32'h200) begin
        errors++; $display("FAIL lock_hold c=%0d got req=%b gnt=%b add=%h exp 1 0000 200", c, s_req_o, m_gnt_o, s_add_o);
      end
      checks++;
      tick();
    end
    s_gnt = 1'b1;
    @(negedge clk);
    if (m_gnt_o !== 4'b0010) begin errors++; $display("FAIL lock_grant got %b exp 0010", m_gnt_o); end
    checks++;
    tick(); m_req = 4'b0001;
    @(negedge clk);
    if (m_gnt_o !== 4'b0001 || s_add_o !== 32'h300) begin
      errors++; $display("FAIL lock_next got %b add=%h exp 0001 300", m_gnt_o, s_add_o);
    end
    checks++;
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_latency();
    int w, outst;
    bit sr;
    logic [3:0] eg, ev;
    do_reset(); l2_en = 1'b1; l2_lat = 6; s_gnt = 1'b1; m_req = 4'b1110;
    outst = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      w = mdl_winner(); sr = mdl_sreq();
      eg = (sr && s_gnt) ? 4'(1 << w) : 4'b0;
      ev = (s_r_valid && mdl_q.size() > 0) ? 4'(1 << mdl_q[0]) : 4'b0;
      if (s_req_o !== sr || m_gnt_o !== eg || m_r_valid_o !== ev) begin
        errors++; $display("FAIL lat_model c=%0d got req=%b gnt=%b rv=%b exp %b %b %b", c, s_req_o, m_gnt_o, m_r_valid_o, sr, eg, ev);
      end
      checks++;
      if ((c == 4 || c == 6) && s_req_o !== 1'b0) begin
        errors++; $display("FAIL lat_full c=%0d got req=%b exp 0", c, s_req_o);
      end
      if (c == 7 && (m_gnt_o !== 4'b0100 || m_r_valid_o !== 4'b0100)) begin
        errors++; $display("FAIL lat_pushpop got gnt=%b rv=%b exp 0100 0100", m_gnt_o, m_r_valid_o);
      end
      if (c == 8 && s_req_o !== 1'b1) begin
        errors++; $display("FAIL lat_keepcnt got req=%b exp 1", s_req_o);
      end
      if (c == 4 || c == 6 || c == 7 || c == 8) checks++;
      outst += (|m_gnt_o) - (|m_r_valid_o);
      if (outst > MO) begin errors++; $display("FAIL lat_outst c=%0d got %0d exp <=4", c, outst); end
      checks++;
      tick();
    end
    idle_inputs(); l2_lat = 1;
    repeat (8) tick();
  endtask

  task automatic test_random();
    int w;
    bit sr;
    logic [3:0] eg, ev, ebe;
    logic [31:0] ea, ewd;
    logic ewen;
    do_reset(); l2_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      m_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) m_req[0] = 1'b0;
      m_wen = 4'($urandom); m_be = 16'($urandom);
      m_add = {$urandom, $urandom, $urandom, $urandom} & {4{32'h0000_00FC}};
      m_wdata = {$urandom, $urandom, $urandom, $urandom};
      s_gnt = ($urandom_range(0, 3) != 0);
      l2_lat = $urandom_range(1, 4);
      @(negedge clk);
      w = mdl_winner(); sr = mdl_sreq();
      eg   = (sr && s_gnt) ? 4'(1 << w) : 4'b0;
      ev   = (s_r_valid && mdl_q.size() > 0) ? 4'(1 << mdl_q[0]) : 4'b0;
      ea   = sr ? m_add[w*32 +: 32] : 32'h0;
      ewd  = sr ? m_wdata[w*32 +: 32] : 32'h0;
      ebe  = sr ? m_be[w*4 +: 4] : 4'h0;
      ewen = sr ? m_wen[w] : 1'b1;
      if (s_req_o !== sr) begin errors++; $display("FAIL rnd_sreq c=%0d got %b exp %b", c, s_req_o, sr); end
      checks++;
      if (m_gnt_o !== eg) begin errors++; $display("FAIL rnd_gnt c=%0d got %b exp %b", c, m_gnt_o, eg); end
      checks++;
      if (m_r_valid_o !== ev) begin errors++; $display("FAIL rnd_rvalid c=%0d got %b exp %b", c, m_r_valid_o, ev); end
      checks++;
      if (s_add_o !== ea || s_wdata_o !== ewd || s_be_o !== ebe || s_wen_o !== ewen) begin
        errors++; $display("FAIL rnd_bus c=%0d got %h %h %h %b exp %h %h %h %b", c, s_add_o, s_wdata_o, s_be_o, s_wen_o, ea, ewd, ebe, ewen);
      end
      checks++;
      if (s_r_valid && m_r_rdata_o !== s_r_rdata) begin
        errors++; $display("FAIL rnd_rdata c=%0d got %h exp %h", c, m_r_rdata_o, s_r_rdata);
      end
      if (s_r_valid) checks++;
      if (err_o !== mdl_err) begin errors++; $display("FAIL rnd_err c=%0d got %b exp %b", c, err_o, mdl_err); end
      checks++;
      tick();
    end
    idle_inputs();
    repeat (12) tick();
  endtask

  task automatic test_reset_mid();
    do_reset(); l2_en = 1'b0; s_gnt = 1'b1; m_req = 4'b0110;
    tick(); tick();
    idle_inputs(); rst = 1'b1;
    @(negedge clk);
    if (s_req_o !== 1'b0 || m_gnt_o !== 4'b0) begin
      errors++; $display("FAIL mid_rst_out got req=%b gnt=%b exp 0 0000", s_req_o, m_gnt_o);
    end
    checks++;
    tick(); rst = 1'b0; s_r_valid = 1'b1; s_r_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    if (m_r_valid_o !== 4'b0) begin errors++; $display("FAIL mid_stray_rv got %b exp 0000", m_r_valid_o); end
    checks++;
    tick();
    @(negedge clk);
    if (err_o !== 1'b1) begin errors++; $display("FAIL mid_err_set got %b exp 1", err_o); end
    checks++;
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    if (err_o !== 1'b0) begin errors++; $display("FAIL mid_err_clr got %b exp 0", err_o); end
    checks++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hi_prio();
    test_lock();
    test_latency();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
